// File: rtl/pps_pkg.sv
// Shared types and constants for the PPS sequence controller.
package pps_pkg;

  localparam int DEPTH = 8;
  localparam int SEL_W = 3;
  localparam int REP_W = 8;
  localparam int IDX_W = 3;
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [REP_W-1:0] rep;
  } tbl_entry_t;

  localparam tbl_entry_t TBL_RST = '{sel: 3'd0, rep: 8'd1};

  // A repeat count of zero behaves as a single period.
  function automatic logic [REP_W-1:0] rep_eff(input logic [REP_W-1:0] rep);
    return (rep == '0) ? REP_W'(1) : rep;
  endfunction

endpackage

// File: rtl/pps_seq_ctrl_if.sv
// Configuration, control and generator-facing signals of the PPS sequencer.
interface pps_seq_ctrl_if
  import pps_pkg::*;
#(
  parameter int WDOG_W = 32
);

  logic              wr_en_i;
  logic [IDX_W-1:0]  wr_addr_i;
  logic [SEL_W-1:0]  wr_sel_i;
  logic [REP_W-1:0]  wr_rep_i;
  logic [LEN_W-1:0]  seq_len_i;
  logic              loop_en_i;
  logic              start_i;
  logic              abort_i;
  logic [WDOG_W-1:0] wdog_lim_i;
  logic              pps_i;

  logic [SEL_W-1:0]  pps_sel_o;
  logic              pps_en_o;
  logic              busy_o;
  logic              done_o;
  logic              err_wdog_o;
  logic              cfg_err_o;
  logic [IDX_W-1:0]  cur_idx_o;
  logic [REP_W-1:0]  per_cnt_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_sel_i, wr_rep_i, seq_len_i, loop_en_i,
           start_i, abort_i, wdog_lim_i, pps_i,
    input  pps_sel_o, pps_en_o, busy_o, done_o, err_wdog_o, cfg_err_o,
           cur_idx_o, per_cnt_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_sel_i, wr_rep_i, seq_len_i, loop_en_i,
           start_i, abort_i, wdog_lim_i, pps_i,
    output pps_sel_o, pps_en_o, busy_o, done_o, err_wdog_o, cfg_err_o,
           cur_idx_o, per_cnt_o
  );

endinterface

// File: rtl/pps_seq_tbl.sv
// Sequence table: DEPTH entries of {sel, rep}, one write port, one async read port.
module pps_seq_tbl
  import pps_pkg::*;
#(
  parameter int DEPTH = pps_pkg::DEPTH
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  tbl_entry_t       wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output tbl_entry_t       rd_data
);

  tbl_entry_t mem [DEPTH];

  // Entry storage; out-of-range writes are dropped.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TBL_RST;
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : TBL_RST;

endmodule

// File: rtl/pps_seq_ctrl.sv
// PPS sequence controller: steps the generator through a table of
// {period select, repeat count} entries, counting PPS falling edges.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | generator off; table writable; waiting for start
//   ST_ARM  | select for entry 0 presented, enable still low (1 cycle)
//   ST_RUN  | generator enabled; counting edges, watchdog running
module pps_seq_ctrl
  import pps_pkg::*;
#(
  parameter int DEPTH  = pps_pkg::DEPTH,
  parameter int WDOG_W = 32
) (
  input  logic           aclk,
  input  logic           aresetn,
  pps_seq_ctrl_if.slave  bus
);

  localparam logic [LEN_W:0] LEN_MAX = (LEN_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic              pps_d;
  logic [IDX_W-1:0]  cur_idx_q, adv_idx, rd_addr;
  logic [REP_W-1:0]  per_cnt_q, rep_q;
  logic [SEL_W-1:0]  sel_q;
  logic [LEN_W-1:0]  len_q;
  logic              loop_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              done_q, cfg_err_q, err_wdog_q;
  tbl_entry_t        rd_data, wr_data;

  logic len_ok, start_ok, start_bad, edge_run, wdog_hit;
  logic rep_last, idx_last, advance, seq_end;

  assign len_ok    = (bus.seq_len_i != '0) && ({1'b0, bus.seq_len_i} <= LEN_MAX);
  assign start_ok  = (state_q == ST_IDLE) && bus.start_i && !bus.abort_i && len_ok;
  assign start_bad = (state_q == ST_IDLE) && bus.start_i && !bus.abort_i && !len_ok;
  assign edge_run  = pps_d && !bus.pps_i && (state_q == ST_RUN);
  assign wdog_hit  = (state_q == ST_RUN) && (bus.wdog_lim_i != '0) && (wdog_q == bus.wdog_lim_i);
  assign rep_last  = (per_cnt_q == rep_q - 8'd1);
  assign idx_last  = ({1'b0, cur_idx_q} == len_q - 4'd1);
  assign advance   = edge_run && rep_last && !bus.abort_i && !wdog_hit;
  assign seq_end   = advance && idx_last && !loop_q;
  assign adv_idx   = idx_last ? '0 : cur_idx_q + 3'd1;
  // In IDLE the read port looks at entry 0 so a start can load it directly.
  assign rd_addr   = (state_q == ST_IDLE) ? '0 : adv_idx;
  assign wr_data   = '{sel: bus.wr_sel_i, rep: bus.wr_rep_i};

  pps_seq_tbl #(.DEPTH(DEPTH)) u_tbl (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (bus.wr_en_i && (state_q == ST_IDLE)),
    .wr_addr (bus.wr_addr_i),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; abort outranks watchdog, which outranks the final advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_ARM;
      ST_ARM:  state_d = bus.abort_i ? ST_IDLE : ST_RUN;
      ST_RUN:  if (bus.abort_i || wdog_hit || seq_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; enable is decoded from state so reset drops it asynchronously.
  always_comb begin
    bus.pps_en_o   = (state_q == ST_RUN);
    bus.busy_o     = (state_q != ST_IDLE);
    bus.pps_sel_o  = sel_q;
    bus.done_o     = done_q;
    bus.err_wdog_o = err_wdog_q;
    bus.cfg_err_o  = cfg_err_q;
    bus.cur_idx_o  = cur_idx_q;
    bus.per_cnt_o  = per_cnt_q;
  end

  // Edge history, entry position, latched config and status flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pps_d      <= 1'b1;
      cur_idx_q  <= '0;
      per_cnt_q  <= '0;
      rep_q      <= 8'd1;
      sel_q      <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      err_wdog_q <= 1'b0;
    end else begin
      pps_d     <= bus.pps_i;
      done_q    <= seq_end;
      cfg_err_q <= start_bad;
      if (start_ok) begin
        err_wdog_q <= 1'b0;
        cur_idx_q  <= '0;
        per_cnt_q  <= '0;
        sel_q      <= rd_data.sel;
        rep_q      <= rep_eff(rd_data.rep);
        len_q      <= bus.seq_len_i;
        loop_q     <= bus.loop_en_i;
      end else if (state_q != ST_IDLE) begin
        if (bus.abort_i) begin
          per_cnt_q <= '0;
        end else if (wdog_hit) begin
          err_wdog_q <= 1'b1;
        end else if (edge_run) begin
          if (rep_last) begin
            per_cnt_q <= '0;
            if (!seq_end) begin
              cur_idx_q <= adv_idx;
              sel_q     <= rd_data.sel;
              rep_q     <= rep_eff(rd_data.rep);
            end
          end else begin
            per_cnt_q <= per_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  // Watchdog: cycles in RUN since entry or the last counted edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wdog_q <= '0;
    end else if (state_q == ST_ARM) begin
      wdog_q <= '0;
    end else if (state_q == ST_RUN) begin
      wdog_q <= edge_run ? '0 : wdog_q + WDOG_W'(1);
    end
  end

endmodule

// File: doc/pps_seq_ctrl.md
PPS_SEQ_CTRL -- requirements
Module: pps_seq_ctrl

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the number of sequence table entries.
REQ-002 The module SHALL have parameter WDOG_W, default 32, giving the watchdog counter width.
REQ-003 aclk  in  1  single clock, 100 MHz; all logic on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 wr_en_i  in  1  table write strobe.
REQ-006 wr_addr_i  in  3  table entry index.
REQ-007 wr_sel_i  in  3  period select code for the entry.
REQ-008 wr_rep_i  in  8  number of periods for the entry; 0 is treated as 1.
REQ-009 seq_len_i  in  4  active entries, valid range 1..DEPTH.
REQ-010 loop_en_i  in  1  wrap to entry 0 after the last entry.
REQ-011 start_i  in  1  one-cycle start pulse.
REQ-012 abort_i  in  1  one-cycle abort pulse.
REQ-013 wdog_lim_i  in  WDOG_W  maximum cycles between PPS edges; 0 disables the watchdog.
REQ-014 pps_i  in  1  active-low PPS from the generator; a falling edge marks one period.
REQ-015 pps_sel_o  out  3  period select to the generator.
REQ-016 pps_en_o  out  1  generator enable.
REQ-017 busy_o  out  1  high from ARM through the end of RUN.
REQ-018 done_o  out  1  one-cycle pulse on normal sequence completion.
REQ-019 err_wdog_o  out  1  sticky watchdog error, cleared by an accepted start.
REQ-020 cfg_err_o  out  1  one-cycle pulse when a start is rejected.
REQ-021 cur_idx_o  out  3  current entry index.
REQ-022 per_cnt_o  out  8  periods counted in the current entry.

Function
REQ-023 The controller SHALL use the states IDLE, ARM and RUN.
REQ-024 Table writes SHALL land on the next clock edge, only in IDLE; writes in ARM or RUN SHALL be ignored.
REQ-025 In IDLE, a start with seq_len_i in 1..DEPTH SHALL latch seq_len_i and loop_en_i, clear err_wdog_o, set cur_idx to 0, drive pps_sel_o with entry 0's select, and go to ARM.
REQ-026 A start with seq_len_i equal to 0 or greater than DEPTH SHALL pulse cfg_err_o for one cycle and stay in IDLE; a start outside IDLE SHALL be ignored.
REQ-027 ARM SHALL last exactly one cycle with pps_en_o low, then go to RUN with pps_en_o high, so pps_sel_o is stable one cycle before enable.
REQ-028 Falling-edge detection on pps_i SHALL register pps_i once (pps_d) and detect an edge when pps_d=1 and pps_i=0.
REQ-029 Edges SHALL be counted only in RUN.
REQ-030 On each counted edge, per_cnt SHALL increment by 1.
REQ-031 When per_cnt reaches the entry's rep value (rep 0 treated as 1), per_cnt SHALL clear to 0 and cur_idx SHALL advance.
REQ-032 On advance, pps_sel_o SHALL update on the cycle after the edge, so the following generator period uses the new select.
REQ-033 Advancing past entry seq_len-1 with loop latched SHALL wrap cur_idx to 0 and stay in RUN.
REQ-034 Advancing past entry seq_len-1 without loop SHALL drop pps_en_o, pulse done_o, and go to IDLE.
REQ-035 The watchdog SHALL clear on entering RUN and on every counted edge, and increment otherwise while in RUN.
REQ-036 When the watchdog equals wdog_lim_i (non-zero), the controller SHALL set err_wdog_o, drop pps_en_o, go to IDLE, and not pulse done_o.
REQ-037 An abort in ARM or RUN SHALL drop pps_en_o on the next cycle, go to IDLE, clear per_cnt, and not pulse done_o.
REQ-038 An abort in IDLE SHALL have no effect.
REQ-039 When abort, watchdog expiry and final advance coincide, priority SHALL be abort, then watchdog, then advance.
REQ-040 When start and abort coincide in IDLE, abort SHALL win and the start SHALL be dropped silently.
REQ-041 cur_idx_o and per_cnt_o SHALL hold their last values in IDLE until the next accepted start.

Reset
REQ-042 On aresetn low, all outputs SHALL go to 0 and the state SHALL go to IDLE.
REQ-043 On aresetn low, pps_d SHALL go to 1 so no false edge is detected after release.
REQ-044 The table contents SHALL reset to sel=0, rep=1.
REQ-045 Reset in the middle of RUN SHALL drop pps_en_o immediately and asynchronously.

Structure
REQ-046 A shared package pps_pkg SHALL hold the state encoding, DEPTH, the sel/rep widths and the table entry struct.
REQ-047 The table SHALL be a sub-module pps_seq_tbl: DEPTH x 11-bit register file, one write port, one asynchronous read port.

Verification (generator in simulation build: sel=1 gives 5000-cycle periods, sel=2 gives 6000)
REQ-048 Bench SHALL cover: table {0:sel1 rep2, 1:sel2 rep1}, len=2, no loop, start -> pps_en_o high 2 cycles after start; pps_sel_o=1 then 2; done_o after the 3rd edge; pps_en_o low.
REQ-049 Bench SHALL cover: same table with loop_en=1 -> cur_idx_o sequence 0,0,1,0,... and no done_o over 6 edges.
REQ-050 Bench SHALL cover: start with seq_len=0 and with seq_len=9 -> cfg_err_o one-cycle pulse, busy_o stays 0.
REQ-051 Bench SHALL cover: wdog_lim=1000, pps_i held high -> err_wdog_o set 1000 cycles into RUN, pps_en_o low, no done_o.
REQ-052 Bench SHALL cover: abort 3 cycles after start -> pps_en_o low next cycle, IDLE, no done_o; a table write during RUN leaves the read-back unchanged.
REQ-053 Bench SHALL cover: aresetn pulsed low in RUN -> all outputs 0 asynchronously; after release, no edge is counted until a real falling edge of pps_i.
